// File: rtl/cam_lookup_client_if.sv
// Handshake bundle around cam_lookup_client: descriptor in, CAM request/response, merged result out.
// slave is the client's view; master is the surrounding environment's view.
interface cam_lookup_client_if #(
   parameter int KEY_SIZE          = 8,
   parameter int VALUE_SIZE        = 32,
   parameter int LOOKUP_USER_WIDTH = 4,
   parameter int META_WIDTH        = 16
);
   logic [KEY_SIZE-1:0]          s_desc_key;
   logic [META_WIDTH-1:0]        s_desc_meta;
   logic                         s_desc_valid;
   logic                         s_desc_ready;
   logic [KEY_SIZE-1:0]          m_lookup_req_index;
   logic [LOOKUP_USER_WIDTH-1:0] m_lookup_req_user;
   logic                         m_lookup_req_valid;
   logic                         m_lookup_req_ready;
   logic [VALUE_SIZE-1:0]        s_lookup_value_data;
   logic [LOOKUP_USER_WIDTH-1:0] s_lookup_value_user;
   logic                         s_lookup_value_valid;
   logic                         s_lookup_value_ready;
   logic [KEY_SIZE-1:0]          m_result_key;
   logic [META_WIDTH-1:0]        m_result_meta;
   logic [VALUE_SIZE-1:0]        m_result_value;
   logic                         m_result_valid;
   logic                         m_result_ready;

   modport slave (
      input  s_desc_key, s_desc_meta, s_desc_valid, m_lookup_req_ready,
      input  s_lookup_value_data, s_lookup_value_user, s_lookup_value_valid, m_result_ready,
      output s_desc_ready, m_lookup_req_index, m_lookup_req_user, m_lookup_req_valid,
      output s_lookup_value_ready, m_result_key, m_result_meta, m_result_value, m_result_valid
   );

   modport master (
      output s_desc_key, s_desc_meta, s_desc_valid, m_lookup_req_ready,
      output s_lookup_value_data, s_lookup_value_user, s_lookup_value_valid, m_result_ready,
      input  s_desc_ready, m_lookup_req_index, m_lookup_req_user, m_lookup_req_valid,
      input  s_lookup_value_ready, m_result_key, m_result_meta, m_result_value, m_result_valid
   );
endinterface

// File: rtl/cam_lookup_client.sv
// In-order CAM lookup client: tags and issues lookups, parks descriptor context in a FIFO,
// and joins each returning value with the head context into a merged result stream.
module cam_lookup_client #(
   parameter int KEY_SIZE          = 8,
   parameter int VALUE_SIZE        = 32,
   parameter int LOOKUP_USER_WIDTH = 4,
   parameter int META_WIDTH        = 16,
   parameter int CTX_DEPTH         = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   cam_lookup_client_if.slave           bus,
   output logic [$clog2(CTX_DEPTH):0]   outstanding,
   output logic                         tag_err
);
   localparam int PW = $clog2(CTX_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = LOOKUP_USER_WIDTH;
   localparam logic [CW-1:0] DEPTH_C = CW'(CTX_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0] TAG_ONE = {{(TW-1){1'b0}}, 1'b1};

   logic [KEY_SIZE-1:0]   req_index_q, req_index_d;
   logic [TW-1:0]         req_user_q, req_user_d;
   logic                  req_valid_q, req_valid_d;
   logic [TW-1:0]         tag_q, tag_d;
   logic [KEY_SIZE-1:0]   ctx_key_q  [CTX_DEPTH];
   logic [KEY_SIZE-1:0]   ctx_key_d  [CTX_DEPTH];
   logic [META_WIDTH-1:0] ctx_meta_q [CTX_DEPTH];
   logic [META_WIDTH-1:0] ctx_meta_d [CTX_DEPTH];
   logic [TW-1:0]         ctx_tag_q  [CTX_DEPTH];
   logic [TW-1:0]         ctx_tag_d  [CTX_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [KEY_SIZE-1:0]   res_key_q, res_key_d;
   logic [META_WIDTH-1:0] res_meta_q, res_meta_d;
   logic [VALUE_SIZE-1:0] res_value_q, res_value_d;
   logic                  res_valid_q, res_valid_d;
   logic                  tag_err_q, tag_err_d;

   logic                  req_free_s, desc_ready_s, push_s;
   logic                  out_free_s, value_ready_s, pop_s;
   logic [KEY_SIZE-1:0]   head_key_s;
   logic [META_WIDTH-1:0] head_meta_s;
   logic [TW-1:0]         head_tag_s;

   // Issue side: accept a descriptor when the request slot frees up and a context slot is available.
   always_comb begin
      req_free_s   = !req_valid_q || bus.m_lookup_req_ready;
      desc_ready_s = req_free_s && (cnt_q < DEPTH_C);
      push_s       = bus.s_desc_valid && desc_ready_s;
      req_index_d  = req_index_q;
      req_user_d   = req_user_q;
      tag_d        = tag_q;
      if (push_s) begin
         req_index_d = bus.s_desc_key;
         req_user_d  = tag_q;
         req_valid_d = 1'b1;
         tag_d       = tag_q + TAG_ONE;
      end else if (bus.m_lookup_req_ready) begin
         req_valid_d = 1'b0;
      end else begin
         req_valid_d = req_valid_q;
      end
   end

   // Response side: join the returning value with the oldest parked context.
   always_comb begin
      out_free_s    = !res_valid_q || bus.m_result_ready;
      value_ready_s = out_free_s && (cnt_q != {CW{1'b0}});
      pop_s         = bus.s_lookup_value_valid && value_ready_s;
      head_key_s    = ctx_key_q[rd_ptr_q];
      head_meta_s   = ctx_meta_q[rd_ptr_q];
      head_tag_s    = ctx_tag_q[rd_ptr_q];
      res_key_d     = res_key_q;
      res_meta_d    = res_meta_q;
      res_value_d   = res_value_q;
      tag_err_d     = tag_err_q;
      if (pop_s) begin
         res_key_d   = head_key_s;
         res_meta_d  = head_meta_s;
         res_value_d = bus.s_lookup_value_data;
         res_valid_d = 1'b1;
         tag_err_d   = tag_err_q | (bus.s_lookup_value_user != head_tag_s);
      end else if (bus.m_result_ready) begin
         res_valid_d = 1'b0;
      end else begin
         res_valid_d = res_valid_q;
      end
   end

   // Context FIFO; full/empty are enforced upstream by the ready terms, so pointers never collide.
   always_comb begin
      ctx_key_d  = ctx_key_q;
      ctx_meta_d = ctx_meta_q;
      ctx_tag_d  = ctx_tag_q;
      if (push_s) begin
         ctx_key_d[wr_ptr_q]  = bus.s_desc_key;
         ctx_meta_d[wr_ptr_q] = bus.s_desc_meta;
         ctx_tag_d[wr_ptr_q]  = tag_q;
         wr_ptr_d             = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; reset discards every in-flight context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_index_q <= '0;
         req_user_q  <= '0;
         req_valid_q <= 1'b0;
         tag_q       <= '0;
         ctx_key_q   <= '{default: '0};
         ctx_meta_q  <= '{default: '0};
         ctx_tag_q   <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         res_key_q   <= '0;
         res_meta_q  <= '0;
         res_value_q <= '0;
         res_valid_q <= 1'b0;
         tag_err_q   <= 1'b0;
      end else begin
         req_index_q <= req_index_d;
         req_user_q  <= req_user_d;
         req_valid_q <= req_valid_d;
         tag_q       <= tag_d;
         ctx_key_q   <= ctx_key_d;
         ctx_meta_q  <= ctx_meta_d;
         ctx_tag_q   <= ctx_tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         res_key_q   <= res_key_d;
         res_meta_q  <= res_meta_d;
         res_value_q <= res_value_d;
         res_valid_q <= res_valid_d;
         tag_err_q   <= tag_err_d;
      end
   end

   assign bus.s_desc_ready         = desc_ready_s;
   assign bus.m_lookup_req_index   = req_index_q;
   assign bus.m_lookup_req_user    = req_user_q;
   assign bus.m_lookup_req_valid   = req_valid_q;
   assign bus.s_lookup_value_ready = value_ready_s;
   assign bus.m_result_key         = res_key_q;
   assign bus.m_result_meta        = res_meta_q;
   assign bus.m_result_value       = res_value_q;
   assign bus.m_result_valid       = res_valid_q;
   assign outstanding              = cnt_q;
   assign tag_err                  = tag_err_q;
endmodule

// File: tb/tb_cam_lookup_client.sv
// Bench for cam_lookup_client: queue-based reference model checked every negedge, a CAM emulator,
// and directed scenarios with literal expectations.
module tb_cam_lookup_client;
   localparam int KW = 8, VW = 32, TW = 4, MW = 16, DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] outstanding;
   logic       tag_err;

   cam_lookup_client_if #(.KEY_SIZE(KW), .VALUE_SIZE(VW), .LOOKUP_USER_WIDTH(TW), .META_WIDTH(MW)) bus();

   cam_lookup_client #(.KEY_SIZE(KW), .VALUE_SIZE(VW), .LOOKUP_USER_WIDTH(TW), .META_WIDTH(MW),
                       .CTX_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(outstanding), .tag_err(tag_err));

   always #5 clk = ~clk;

   typedef struct { logic [KW-1:0] key; logic [MW-1:0] meta; logic [TW-1:0] tag; } ctx_t;
   typedef struct { logic [KW-1:0] key; logic [MW-1:0] meta; } desc_t;
   typedef struct { logic [KW-1:0] key; logic [MW-1:0] meta; logic [VW-1:0] value; } res_t;

   int n_checks = 0, n_fail = 0;
   ctx_t ctx_m[$];
   ctx_t cam_q[$];
   desc_t desc_src[$];
   res_t res_log[$];
   bit er_valid, eo_valid, etag_err, desc_fire, val_fire;
   logic [KW-1:0] er_key;
   logic [TW-1:0] er_tag;
   res_t eo;
   int next_tag, n_res = 0, n_pop = 0;
   int p_desc = 100, p_reqr = 100, p_val = 100, p_resr = 100;
   int resp_budget = -1, corrupt_idx = -1, resp_seq = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic desc_t mk(input int i);
      desc_t d;
      d.key  = 8'(8'h30 + i * 7);
      d.meta = 16'(16'h1000 + i * 16'h0111);
      return d;
   endfunction

   function automatic int counter(input int sel);
      case (sel)
         0:       return n_res;
         1:       return ctx_m.size();
         2:       return n_pop;
         default: return 0;
      endcase
   endfunction

   // Reference model: compare DUT against model state, then advance the model using current inputs.
   always @(negedge clk) begin
      bit drdy_e, vrdy_e;
      ctx_t head;
      if (!rst_n) begin
         check("rst_req_valid", 64'(bus.m_lookup_req_valid), 64'd0);
         check("rst_req_data", 64'({bus.m_lookup_req_index, bus.m_lookup_req_user}), 64'd0);
         check("rst_res_valid", 64'(bus.m_result_valid), 64'd0);
         check("rst_res_data", 64'({bus.m_result_key, bus.m_result_meta, bus.m_result_value}), 64'd0);
         check("rst_outstanding", 64'(outstanding), 64'd0);
         check("rst_tag_err", 64'(tag_err), 64'd0);
         ctx_m.delete(); cam_q.delete();
         er_valid = 0; eo_valid = 0; etag_err = 0; desc_fire = 0; val_fire = 0; next_tag = 0;
      end else begin
         drdy_e = (!er_valid || bus.m_lookup_req_ready) && ctx_m.size() < DEPTH;
         vrdy_e = (!eo_valid || bus.m_result_ready) && ctx_m.size() != 0;
         check("desc_ready", 64'(bus.s_desc_ready), 64'(drdy_e));
         check("req_valid", 64'(bus.m_lookup_req_valid), 64'(er_valid));
         if (er_valid) begin
            check("req_index", 64'(bus.m_lookup_req_index), 64'(er_key));
            check("req_user", 64'(bus.m_lookup_req_user), 64'(er_tag));
         end
         check("value_ready", 64'(bus.s_lookup_value_ready), 64'(vrdy_e));
         check("res_valid", 64'(bus.m_result_valid), 64'(eo_valid));
         if (eo_valid) begin
            check("res_key", 64'(bus.m_result_key), 64'(eo.key));
            check("res_meta", 64'(bus.m_result_meta), 64'(eo.meta));
            check("res_value", 64'(bus.m_result_value), 64'(eo.value));
         end
         check("outstanding", 64'(outstanding), 64'(ctx_m.size()));
         check("tag_err", 64'(tag_err), 64'(etag_err));

         desc_fire = bus.s_desc_valid && drdy_e;
         val_fire  = bus.s_lookup_value_valid && vrdy_e;
         if (er_valid && bus.m_lookup_req_ready) cam_q.push_back('{er_key, 16'h0000, er_tag});
         if (eo_valid && bus.m_result_ready) begin
            res_log.push_back('{bus.m_result_key, bus.m_result_meta, bus.m_result_value});
            n_res++;
         end
         if (val_fire) begin
            head = ctx_m.pop_front();
            if (bus.s_lookup_value_user != head.tag) etag_err = 1;
            eo = '{head.key, head.meta, bus.s_lookup_value_data};
            eo_valid = 1;
            n_pop++;
         end else if (eo_valid && bus.m_result_ready) eo_valid = 0;
         if (desc_fire) begin
            ctx_m.push_back('{bus.s_desc_key, bus.s_desc_meta, TW'(next_tag)});
            er_valid = 1; er_key = bus.s_desc_key; er_tag = TW'(next_tag);
            next_tag = (next_tag + 1) % (1 << TW);
         end else if (er_valid && bus.m_lookup_req_ready) er_valid = 0;
      end
   end

   // Environment driver: descriptor source, CAM emulator (in-order responses) and sink readiness.
   task automatic drive();
      desc_t d;
      ctx_t e;
      bus.m_lookup_req_ready = int'($urandom_range(99)) < p_reqr;
      bus.m_result_ready     = int'($urandom_range(99)) < p_resr;
      if (!rst_n) begin
         bus.s_desc_valid = 1'b0;
         bus.s_lookup_value_valid = 1'b0;
      end else begin
         if (!bus.s_desc_valid || desc_fire) begin
            if (desc_src.size() > 0 && int'($urandom_range(99)) < p_desc) begin
               d = desc_src.pop_front();
               bus.s_desc_valid = 1'b1; bus.s_desc_key = d.key; bus.s_desc_meta = d.meta;
            end else bus.s_desc_valid = 1'b0;
         end
         if (!bus.s_lookup_value_valid || val_fire) begin
            if (cam_q.size() > 0 && resp_budget != 0 && int'($urandom_range(99)) < p_val) begin
               e = cam_q.pop_front();
               resp_seq++;
               bus.s_lookup_value_valid = 1'b1;
               bus.s_lookup_value_data  = 32'hCAFE_0000 + 32'(resp_seq);
               bus.s_lookup_value_user  = (resp_seq - 1 == corrupt_idx) ? e.tag + 4'd1 : e.tag;
               if (resp_budget > 0) resp_budget--;
            end else bus.s_lookup_value_valid = 1'b0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         drive();
      end
   end

   task automatic wait_until(input string name, input int sel, input int target, input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk); #3;
         done = counter(sel) >= target;
      end
      check({name, "_timeout"}, 64'(done), 64'd1);
   endtask

   task automatic reset_dut();
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_req_valid", 64'(bus.m_lookup_req_valid), 64'd0);
      check("async_res_valid", 64'(bus.m_result_valid), 64'd0);
      check("async_outstanding", 64'(outstanding), 64'd0);
      check("async_tag_err", 64'(tag_err), 64'd0);
      desc_src.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int base;
      bit got;
      bus.s_desc_valid = 1'b0; bus.s_desc_key = '0; bus.s_desc_meta = '0;
      bus.s_lookup_value_valid = 1'b0; bus.s_lookup_value_data = '0; bus.s_lookup_value_user = '0;
      bus.m_lookup_req_ready = 1'b0; bus.m_result_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Single descriptor round trip.
      resp_seq = 0; res_log.delete(); base = n_res;
      desc_src.push_back('{8'h12, 16'hBEEF});
      wait_until("t1_result", 0, base + 1, 40);
      if (res_log.size() >= 1) begin
         check("t1_key", 64'(res_log[0].key), 64'h12);
         check("t1_meta", 64'(res_log[0].meta), 64'hBEEF);
         check("t1_value", 64'(res_log[0].value), 64'hCAFE_0001);
      end
      check("t1_tag_err", 64'(tag_err), 64'd0);
      check("t1_outstanding", 64'(outstanding), 64'd0);

      // Fill to depth, then one pop reopens acceptance the following cycle.
      reset_dut();
      p_val = 0; base = n_res;
      for (int i = 0; i < 9; i++) desc_src.push_back(mk(i));
      wait_until("t2_fill", 1, 8, 60);
      repeat (3) begin
         @(posedge clk); #3;
         check("t2_outstanding_full", 64'(outstanding), 64'd8);
         check("t2_desc_ready_full", 64'(bus.s_desc_ready), 64'd0);
      end
      p_val = 100; resp_budget = 1;
      wait_until("t2_pop", 2, n_pop + 1, 20);
      check("t2_outstanding_after_pop", 64'(outstanding), 64'd7);
      check("t2_desc_ready_after_pop", 64'(bus.s_desc_ready), 64'd1);
      resp_budget = -1;
      wait_until("t2_drain", 0, base + 9, 100);

      // 40 descriptors with stalls everywhere; tags wrap past 15.
      res_log.delete(); resp_seq = 0; base = n_res;
      p_desc = 70; p_reqr = 70; p_val = 70; p_resr = 70;
      for (int i = 0; i < 40; i++) desc_src.push_back(mk(i + 20));
      wait_until("t3_stream", 0, base + 40, 3000);
      p_desc = 100; p_reqr = 100; p_val = 100; p_resr = 100;
      check("t3_count", 64'(res_log.size()), 64'd40);
      for (int k = 0; k < 40 && k < res_log.size(); k++) begin
         check("t3_order_key", 64'(res_log[k].key), 64'(mk(k + 20).key));
         check("t3_order_meta", 64'(res_log[k].meta), 64'(mk(k + 20).meta));
         check("t3_order_value", 64'(res_log[k].value), 64'(32'hCAFE_0000 + 32'(k + 1)));
      end
      check("t3_tag_err", 64'(tag_err), 64'd0);

      // Tag mismatch on the third response: result still emitted, flag sticks.
      reset_dut();
      res_log.delete(); resp_seq = 0; corrupt_idx = 2; base = n_res;
      for (int i = 0; i < 4; i++) desc_src.push_back(mk(i + 70));
      wait_until("t4_results", 0, base + 4, 60);
      corrupt_idx = -1;
      check("t4_tag_err", 64'(tag_err), 64'd1);
      if (res_log.size() >= 3) begin
         check("t4_key", 64'(res_log[2].key), 64'(mk(72).key));
         check("t4_value", 64'(res_log[2].value), 64'hCAFE_0003);
      end
      repeat (5) @(posedge clk);
      #3 check("t4_tag_err_sticky", 64'(tag_err), 64'd1);

      // Output backpressure blocks the response side and holds the result.
      reset_dut();
      p_resr = 0; base = n_res;
      for (int i = 0; i < 2; i++) desc_src.push_back(mk(i + 90));
      wait_until("t5_first_pop", 2, n_pop + 1, 40);
      repeat (4) begin
         @(posedge clk); #3;
         check("t5_value_ready", 64'(bus.s_lookup_value_ready), 64'd0);
         check("t5_res_valid", 64'(bus.m_result_valid), 64'd1);
         check("t5_res_key", 64'(bus.m_result_key), 64'(mk(90).key));
         check("t5_outstanding", 64'(outstanding), 64'd1);
      end
      p_resr = 100;
      wait_until("t5_drain", 0, base + 2, 40);

      // Reset mid-stream with 5 outstanding; tag restarts at 0.
      p_val = 0;
      for (int i = 0; i < 5; i++) desc_src.push_back(mk(i + 100));
      wait_until("t6_fill", 1, 5, 40);
      check("t6_outstanding_pre", 64'(outstanding), 64'd5);
      reset_dut();
      p_val = 100;
      desc_src.push_back('{8'h5A, 16'h1234});
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #3;
         got = bus.m_lookup_req_valid;
      end
      check("t6_req_seen", 64'(got), 64'd1);
      check("t6_req_user_restart", 64'(bus.m_lookup_req_user), 64'd0);
      check("t6_req_index", 64'(bus.m_lookup_req_index), 64'h5A);
      wait_until("t6_drain", 1, 0, 40);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cam_lookup_client.md
Name: cam_lookup_client

Overview:
- In-order lookup client that sits directly upstream and downstream of the CAM lookup path.
- Accepts packet descriptors (key + metadata) and issues lookup requests tagged with a sequence number on the user field.
- Parks each descriptor's context in an internal context FIFO while the lookup is outstanding.
- Joins each returning lookup value with the head context and emits a merged result stream.
- Bounds outstanding lookups and checks that response tags arrive in issue order.

Parameters:
KEY_SIZE, 8, lookup key width
VALUE_SIZE, 32, lookup value width
LOOKUP_USER_WIDTH, 4, tag width carried on request/response user fields
META_WIDTH, 16, per-descriptor metadata width carried around the CAM
CTX_DEPTH, 8, max outstanding lookups; power of two, must be <= 2**LOOKUP_USER_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_desc_key  in  KEY_SIZE  descriptor key
s_desc_meta  in  META_WIDTH  descriptor metadata
s_desc_valid  in  1  descriptor valid
s_desc_ready  out  1  descriptor ready
m_lookup_req_index  out  KEY_SIZE  lookup key to CAM
m_lookup_req_user  out  LOOKUP_USER_WIDTH  issue tag
m_lookup_req_valid  out  1  request valid
m_lookup_req_ready  in  1  request ready
s_lookup_value_data  in  VALUE_SIZE  returned value
s_lookup_value_user  in  LOOKUP_USER_WIDTH  returned tag
s_lookup_value_valid  in  1  response valid
s_lookup_value_ready  out  1  response ready
m_result_key  out  KEY_SIZE  original key
m_result_meta  out  META_WIDTH  original metadata
m_result_value  out  VALUE_SIZE  looked-up value
m_result_valid  out  1  result valid
m_result_ready  in  1  result ready
outstanding  out  $clog2(CTX_DEPTH)+1  contexts currently held
tag_err  out  1  sticky tag-mismatch flag

Behaviour:
- Reset (rst_n low, async): m_lookup_req_valid=0, m_result_valid=0, all data outputs 0, issue tag=0, context FIFO empty, outstanding=0, tag_err=0.
- Any in-flight context is discarded on reset; no result is emitted for it.
- Issue side:
  - req_free = !m_lookup_req_valid || m_lookup_req_ready.
  - s_desc_ready = req_free && (outstanding < CTX_DEPTH). This is combinational and does not depend on s_desc_valid.
  - On descriptor handshake: load request register {index=key, user=tag}; valid asserts the next cycle (1-cycle latency).
  - Same handshake pushes {key, meta, tag} into the context FIFO and increments the tag modulo 2**LOOKUP_USER_WIDTH (wraps 15->0 at default width).
  - Request register holds stable while valid && !ready.
  - A back-to-back handshake every cycle must be sustained at full throughput.
- Response side:
  - out_free = !m_result_valid || m_result_ready.
  - s_lookup_value_ready = out_free && (outstanding != 0). A response arriving with the FIFO empty is stalled, never dropped.
  - On response handshake: pop the head context; load the output register with {head.key, head.meta, data}. m_result_valid asserts the next cycle.
  - If s_lookup_value_user != head.tag, set tag_err=1. tag_err clears only on reset; the result is still emitted.
- Context FIFO:
  - Push and pop in the same cycle leave outstanding unchanged.
  - Push is blocked when full; pop is blocked when empty.
  - outstanding is registered and equals the count after the current edge.
- Full/empty boundaries:
  - At outstanding=CTX_DEPTH, s_desc_ready=0.
  - If a pop occurs in that cycle, a push becomes legal the following cycle. No combinational full-to-ready bypass.
- Ordering: results leave in descriptor acceptance order.

Test Plan:
- Single descriptor key=0x12, meta=0xBEEF; CAM returns data=0xCAFE0001 with user=0 -> one request {0x12, user 0} one cycle after accept; result {0x12, 0xBEEF, 0xCAFE0001}; tag_err=0; outstanding 1->0.
- Issue 8 descriptors with m_lookup_req_ready=1 and no responses -> 8 accepted, outstanding=8, s_desc_ready=0. Return 1 response -> outstanding=7; s_desc_ready=1 the following cycle.
- Stream 40 descriptors with random ready/valid stalls on all three interfaces -> 40 results in order with correct key/meta/value pairs; tags wrap 15->0 with no tag_err.
- Response user=3 while head tag=2 -> result still emitted with head context; tag_err=1 and stays 1 until reset.
- m_result_ready=0 with a result pending -> s_lookup_value_ready=0; output holds stable; no context is popped.
- Assert rst_n low mid-stream with 5 outstanding -> all valids 0 and outstanding=0 immediately (async). After release, tag restarts at 0.
